// File: rtl/rv32_exec_pkg.sv
// Shared encodings for the RV32I integer execute stage: operation classes
// and the funct3 values decoded by the ALU and the branch comparator.
package rv32_exec_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Operation class driven by the decoder alongside the operands.
    localparam logic [1:0] OPC_R    = 2'b00;
    localparam logic [1:0] OPC_I    = 2'b01;
    localparam logic [1:0] OPC_B    = 2'b10;
    localparam logic [1:0] OPC_NONE = 2'b11;

    // ALU funct3 (R and I classes).
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3 (B class); 010 and 011 are not branches.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/rv32_alu_core.sv
// Combinational 32-bit ALU shared by register-register and
// register-immediate operations. alt selects SUB over ADD and arithmetic
// over logical right shift; the caller masks it where it must not apply.
module rv32_alu_core
    import rv32_exec_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    input  logic        alt,
    output logic [31:0] y
);

    logic [4:0]  shamt;
    logic [31:0] xor_bits;
    logic [31:0] or_bits;
    logic [31:0] and_bits;

    // Only the low five bits of operand B form the shift amount.
    assign shamt = b[4:0];

    // Bitwise logic ops, one slice per bit.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_logic
            assign xor_bits[gi] = a[gi] ^ b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign and_bits[gi] = a[gi] & b[gi];
        end
    endgenerate

    // Select the operation result by funct3.
    always_comb begin
        y = 32'h0;
        case (funct3)
            F3_ADD:  y = alt ? (a - b) : (a + b);
            F3_SLL:  y = a << shamt;
            F3_SLT:  y = {31'h0, ($signed(a) < $signed(b))};
            F3_SLTU: y = {31'h0, (a < b)};
            F3_XOR:  y = xor_bits;
            F3_SR:   y = alt ? 32'($signed(a) >>> shamt) : (a >> shamt);
            F3_OR:   y = or_bits;
            F3_AND:  y = and_bits;
            default: y = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32_int_exec.sv
// Registered RV32I execute stage: ALU results for R/I classes, branch
// decision and target for the B class, one cycle from accept to output.
module rv32_int_exec
    import rv32_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      op_class,
    input  logic [2:0]      funct3,
    input  logic            bit_th,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] rv2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] iaddr,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] br_target,
    output logic            br_taken
);

    logic [XLEN-1:0] alu_b;
    logic            alu_alt;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] result_next;
    logic [XLEN-1:0] target_next;
    logic            taken_next;

    logic            out_valid_reg;
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] br_target_reg;
    logic            br_taken_reg;

    // I-class takes the immediate as operand B; ADDI has no subtract form,
    // so bit 30 is ignored there (it is part of the immediate).
    assign alu_b   = (op_class == OPC_I) ? imm : rv2;
    assign alu_alt = bit_th & ~((op_class == OPC_I) && (funct3 == F3_ADD));

    rv32_alu_core u_alu (
        .a      (rv1),
        .b      (alu_b),
        .funct3 (funct3),
        .alt    (alu_alt),
        .y      (alu_y)
    );

    // Branch target is computed for every accepted op, wrapping mod 2^32.
    assign target_next = iaddr + imm;

    // Branch comparator and result select; non-branches never take.
    always_comb begin
        result_next = '0;
        taken_next  = 1'b0;
        case (op_class)
            OPC_R, OPC_I: result_next = alu_y;
            OPC_B: begin
                case (funct3)
                    F3_BEQ:  taken_next = (rv1 == rv2);
                    F3_BNE:  taken_next = (rv1 != rv2);
                    F3_BLT:  taken_next = ($signed(rv1) <  $signed(rv2));
                    F3_BGE:  taken_next = ($signed(rv1) >= $signed(rv2));
                    F3_BLTU: taken_next = (rv1 <  rv2);
                    F3_BGEU: taken_next = (rv1 >= rv2);
                    default: taken_next = 1'b0;
                endcase
            end
            default: begin
                result_next = '0;
                taken_next  = 1'b0;
            end
        endcase
    end

    // Output registers: reset clears all, a bubble clears the strobes and
    // holds the data fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            br_target_reg <= '0;
            br_taken_reg  <= 1'b0;
        end else if (in_valid) begin
            out_valid_reg <= 1'b1;
            result_reg    <= result_next;
            br_target_reg <= target_next;
            br_taken_reg  <= taken_next;
        end else begin
            out_valid_reg <= 1'b0;
            result_reg    <= result_reg;
            br_target_reg <= br_target_reg;
            br_taken_reg  <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign br_target = br_target_reg;
    assign br_taken  = br_taken_reg;

endmodule

// File: tb/tb_rv32_int_exec.sv
// Directed bench for rv32_int_exec with hand-computed expected values.
module tb_rv32_int_exec;
    import rv32_exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  op_class;
    logic [2:0]  funct3;
    logic        bit_th;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [31:0] imm;
    logic [31:0] iaddr;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] br_target;
    logic        br_taken;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rv32_int_exec dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .op_class  (op_class),
        .funct3    (funct3),
        .bit_th    (bit_th),
        .rv1       (rv1),
        .rv2       (rv2),
        .imm       (imm),
        .iaddr     (iaddr),
        .out_valid (out_valid),
        .result    (result),
        .br_target (br_target),
        .br_taken  (br_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op, clock it in, then sample just after the edge.
    task automatic do_op(input logic [1:0] cls, input logic [2:0] f3, input logic th,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc);
        in_valid = 1'b1;
        op_class = cls;
        funct3   = f3;
        bit_th   = th;
        rv1      = a;
        rv2      = b;
        imm      = im;
        iaddr    = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_r(input string tag, input logic [31:0] exp);
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, ".result"}, result, exp);
        check({tag, ".taken"}, {31'h0, br_taken}, 32'h0);
        $display("op %s result=%h", tag, result);
    endtask

    task automatic check_b(input string tag, input logic exp_taken);
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, ".result"}, result, 32'h0);
        check({tag, ".target"}, br_target, 32'h0000_00F8);
        check({tag, ".taken"}, {31'h0, br_taken}, {31'h0, exp_taken});
        $display("br %s taken=%0b target=%h", tag, br_taken, br_target);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, ".result"}, result, 32'h0);
        check({tag, ".target"}, br_target, 32'h0);
        check({tag, ".taken"}, {31'h0, br_taken}, 32'h0);
        $display("reset %s valid=%0b result=%h", tag, out_valid, result);
    endtask

    initial begin
        // Reset held with a valid op presented: reset wins.
        reset = 1'b1;
        in_valid = 1'b1; op_class = OPC_R; funct3 = F3_ADD; bit_th = 1'b0;
        rv1 = 32'd5; rv2 = 32'd7; imm = 32'h0; iaddr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        reset = 1'b0;
        do_op(OPC_R, F3_ADD, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
        check_r("add_5_7", 32'd12);

        // R class
        do_op(OPC_R, F3_ADD, 1'b1, 32'h0, 32'h1, 32'h0, 32'h0);
        check_r("sub_0_1", 32'hFFFF_FFFF);
        do_op(OPC_R, F3_SR, 1'b1, 32'h8000_0000, 32'h0000_0024, 32'h0, 32'h0);
        check_r("sra", 32'hF800_0000);
        do_op(OPC_R, F3_SR, 1'b0, 32'h8000_0000, 32'h0000_0024, 32'h0, 32'h0);
        check_r("srl", 32'h0800_0000);
        do_op(OPC_R, F3_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
        check_r("slt", 32'h1);
        do_op(OPC_R, F3_SLTU, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
        check_r("sltu", 32'h0);
        do_op(OPC_R, F3_SLL, 1'b0, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0, 32'h0);
        check_r("sll", 32'h0000_0030);
        do_op(OPC_R, F3_OR, 1'b0, 32'hF000_000F, 32'h0F00_00F0, 32'h0, 32'h0);
        check_r("or", 32'hFF00_00FF);

        // I class: rv2 deliberately non-zero so a wrong operand mux shows.
        do_op(OPC_I, F3_ADD, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFD, 32'h0);
        check_r("addi_th", 32'd7);
        do_op(OPC_I, F3_SR, 1'b1, 32'hFFFF_FFF0, 32'd99, 32'd2, 32'h0);
        check_r("srai", 32'hFFFF_FFFC);
        do_op(OPC_I, F3_SLTU, 1'b0, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'h0);
        check_r("sltiu", 32'h1);
        do_op(OPC_I, F3_AND, 1'b0, 32'h0000_FF0F, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0);
        check_r("andi", 32'h0);
        do_op(OPC_I, F3_XOR, 1'b0, 32'h0000_00FF, 32'h0, 32'hFFFF_FFFF, 32'h0);
        check_r("xori", 32'hFFFF_FF00);

        // B class, target 0x100 + (-8) = 0xF8
        do_op(OPC_B, F3_BEQ, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFF8, 32'h100);
        check_b("beq", 1'b1);
        do_op(OPC_B, F3_BNE, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFF8, 32'h100);
        check_b("bne", 1'b0);
        do_op(OPC_B, F3_BLT, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF8, 32'h100);
        check_b("blt", 1'b1);
        do_op(OPC_B, F3_BLTU, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF8, 32'h100);
        check_b("bltu", 1'b0);
        do_op(OPC_B, F3_BGE, 1'b0, 32'd42, 32'd42, 32'hFFFF_FFF8, 32'h100);
        check_b("bge_eq", 1'b1);
        do_op(OPC_B, F3_BGEU, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFF8, 32'h100);
        check_b("bgeu", 1'b0);
        do_op(OPC_B, 3'b010, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFF8, 32'h100);
        check_b("b_illegal", 1'b0);

        // Class none: result 0, no branch, target still computed.
        do_op(OPC_NONE, F3_ADD, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFF8, 32'h100);
        check_b("none", 1'b0);

        // Back-to-back ops, then bubbles.
        do_op(OPC_R, F3_ADD, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0);
        check_r("b2b_add", 32'd3);
        do_op(OPC_R, F3_XOR, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 32'h0);
        check_r("b2b_xor", 32'h0000_FF00);
        do_op(OPC_B, F3_BEQ, 1'b0, 32'd9, 32'd9, 32'hFFFF_FFF8, 32'h100);
        check_b("b2b_beq", 1'b1);
        bubble();
        check("bub1.valid", {31'h0, out_valid}, 32'h0);
        check("bub1.taken", {31'h0, br_taken}, 32'h0);
        check("bub1.target", br_target, 32'h0000_00F8);
        $display("bubble valid=%0b taken=%0b", out_valid, br_taken);
        do_op(OPC_I, F3_ADD, 1'b0, 32'h50, 32'h0, 32'h5, 32'h0);
        check_r("pre_bub", 32'h55);
        bubble();
        check("bub2.valid", {31'h0, out_valid}, 32'h0);
        check("bub2.result", result, 32'h55);
        check("bub2.target", br_target, 32'h5);
        $display("bubble valid=%0b result=%h", out_valid, result);

        // Reset mid-stream with a valid op presented.
        do_op(OPC_B, F3_BEQ, 1'b0, 32'd1, 32'd1, 32'hFFFF_FFF8, 32'h100);
        check_b("pre_rst", 1'b1);
        reset = 1'b1;
        do_op(OPC_R, F3_ADD, 1'b0, 32'd1, 32'd1, 32'h4, 32'h4);
        check_zero("rst_mid");
        reset = 1'b0;
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rv32_int_exec.md
Name: rv32_int_exec

Overview:
- Registered RV32I integer execute block for the CPU's ALU stage.
- Computes R-type register-register results, I-type register-immediate results, and B-type branch decisions with their targets.
- Replaces the combinational R/I/B compute helpers with a single clocked unit.
- One cycle of latency from accepted input to valid output.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the operands on this cycle are to be executed.
- op_class  input  2  operation class: 00 = R, 01 = I, 10 = B, 11 = none.
- funct3  input  3  instruction funct3 field.
- bit_th  input  1  instruction bit 30 (funct7[5]); selects SUB or SRA/SRAI.
- rv1  input  32  register source 1.
- rv2  input  32  register source 2.
- imm  input  32  sign-extended immediate, interpreted as signed.
- iaddr  input  32  PC of the instruction.
- out_valid  output  1  registered result is valid.
- result  output  32  R/I result; 0 for B or none.
- br_target  output  32  iaddr + imm.
- br_taken  output  1  branch condition met.

Behaviour:
- Reset: on a clk edge with reset=1, out_valid, result, br_target and br_taken all go to 0. Reset has priority over in_valid.
- Latency:
  - Inputs are sampled on the edge where in_valid=1.
  - Outputs update on that same edge and are visible in the following cycle.
  - Back-to-back inputs are accepted every cycle; there is no backpressure.
- in_valid=0: out_valid and br_taken go to 0; result and br_target hold their previous values.
- R class (operand B = rv2), selected by funct3:
  - 000: ADD, or SUB when bit_th=1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when bit_th=1.
  - 110: OR.
  - 111: AND.
- I class (operand B = imm): same table as R, except:
  - funct3 000 is always ADDI; bit_th is ignored.
  - 101 selects SRLI, or SRAI when bit_th=1.
- Arithmetic rules:
  - Add and subtract wrap modulo 2^32.
  - Shift amount is operand B[4:0]; upper bits are ignored.
  - SRA/SRAI replicate bit 31.
  - SLT/SLTU produce 32'h1 or 32'h0.
  - br_taken is 0 for the R and I classes.
- B class:
  - br_target = iaddr + imm, wrapping.
  - result = 0.
  - br_taken by funct3:
    - 000 BEQ: rv1 == rv2.
    - 001 BNE: rv1 != rv2.
    - 100 BLT: signed rv1 < rv2.
    - 101 BGE: signed rv1 >= rv2.
    - 110 BLTU: unsigned rv1 < rv2.
    - 111 BGEU: unsigned rv1 >= rv2.
    - 010 and 011 are illegal: br_taken = 0, target still computed.
- Class "none" (11): result = 0, br_taken = 0; br_target is still computed. out_valid follows in_valid.
- Signed comparisons must use the signed interpretation at the 32'h8000_0000 / 32'h7FFF_FFFF boundary.
- No X propagation: every output is assigned on every edge branch.

Decomposition:
- Package rv32_exec_pkg holds:
  - op_class encodings: OPC_R, OPC_I, OPC_B, OPC_NONE.
  - funct3 constants: F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND, F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
- One sub-module, rv32_alu_core: a combinational 32-bit ALU taking a (rv1), b (rv2 or imm, muxed in the top), funct3, and an alt flag (bit_th, masked to 0 for I-class funct3 000). It is shared by the R and I classes.
- Branch compare and target adder live in the top level.
- Output registers live in the top level.

Test Plan:
- Reset: hold reset=1 with in_valid=1 → out_valid=0, result=0, br_target=0, br_taken=0. Release reset with R ADD, rv1=5, rv2=7 → next cycle result=12, out_valid=1.
- R arithmetic:
  - SUB rv1=0, rv2=1 → 32'hFFFF_FFFF.
  - SRA rv1=32'h8000_0000, rv2=32'h0000_0024 (shamt 4) → 32'hF800_0000.
  - SRL, same operands → 32'h0800_0000.
  - SLT rv1=32'hFFFF_FFFF, rv2=1 → 1.
  - SLTU, same operands → 0.
- I class:
  - ADDI with bit_th=1, rv1=10, imm=-3 → 7 (no subtract).
  - SRAI bit_th=1, rv1=-16, imm=2 → -4.
  - SLTIU rv1=0, imm=-1 → 1.
  - ANDI rv1=32'hFF0F, imm=32'h0F0 → 32'h0000_0000.
- Branches, all with iaddr=32'h100, imm=-8 → br_target=32'hF8:
  - BEQ 3,3 → taken.
  - BNE 3,3 → not taken.
  - BLT 32'h8000_0000 vs 32'h7FFF_FFFF → taken.
  - BLTU, same operands → not taken.
  - BGE equal operands → taken.
  - BGEU 0 vs 1 → not taken.
  - funct3=010 → not taken.
- Throughput and hold:
  - Three back-to-back valid ops → three consecutive correct outputs.
  - A bubble (in_valid=0) → out_valid=0 and br_taken=0, result held unchanged.
  - Reset asserted mid-stream → all outputs 0 on the next edge.
